// File: rtl/unidade_controle_multiciclo.sv
// Multicycle processor control unit: Moore FSM whose outputs are registered from the next state.
// Defining CTRL_CONTADOR_INSTR_EN adds the retired-instruction counter on instr_count.

module unidade_controle_multiciclo #(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned ALU_W    = 3,
    parameter int unsigned COMP_W   = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                inp_valid,
    input  logic                continuar,
    output logic                ir_load,
    output logic                pc_inc,
    output logic [1:0]          condicional,
    output logic [ALU_W-1:0]    aluCtrl,
    output logic [COMP_W-1:0]   comp,
    output logic                escolhaReg,
    output logic                imediato,
    output logic                origemEscrita,
    output logic                memRead,
    output logic                memWrite,
    output logic                regWrite,
    output logic                out,
    output logic                inp,
    output logic                escolheExt,
    output logic                halted,
    output logic                ilegal,
    output logic [31:0]         instr_count
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned CNT_W = 32;

    // Opcode map; 11001..11111 are undefined
    localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR    = 5'b00011;
    localparam logic [OP_W-1:0] OP_MULT  = 5'b00100;
    localparam logic [OP_W-1:0] OP_DIV   = 5'b00101;
    localparam logic [OP_W-1:0] OP_SLT   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SGT   = 5'b00111;
    localparam logic [OP_W-1:0] OP_JUMP  = 5'b01000;
    localparam logic [OP_W-1:0] OP_LW    = 5'b01001;
    localparam logic [OP_W-1:0] OP_SW    = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'b01011;
    localparam logic [OP_W-1:0] OP_SUBI  = 5'b01100;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'b01101;
    localparam logic [OP_W-1:0] OP_BNEQ  = 5'b01110;
    localparam logic [OP_W-1:0] OP_ANDI  = 5'b01111;
    localparam logic [OP_W-1:0] OP_HALT  = 5'b10000;
    localparam logic [OP_W-1:0] OP_ORI   = 5'b10001;
    localparam logic [OP_W-1:0] OP_MULTI = 5'b10010;
    localparam logic [OP_W-1:0] OP_OUT   = 5'b10011;
    localparam logic [OP_W-1:0] OP_BEQZ  = 5'b10100;
    localparam logic [OP_W-1:0] OP_MOVE  = 5'b10101;
    localparam logic [OP_W-1:0] OP_NOP   = 5'b10110;
    localparam logic [OP_W-1:0] OP_BEQO  = 5'b10111;
    localparam logic [OP_W-1:0] OP_INPUT = 5'b11000;

    typedef enum logic [2:0] {
        BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESPERA_ENTRADA, ESCRITA, PARADO
    } estado_t;

    typedef struct packed {
        logic              ir_load;
        logic              pc_inc;
        logic [1:0]        condicional;
        logic [ALU_W-1:0]  alu;
        logic [COMP_W-1:0] comp;
        logic              escolha_reg;
        logic              imediato;
        logic              origem_escrita;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              saida;
        logic              entrada;
        logic              escolhe_ext;
        logic              halted;
        logic              ilegal;
    } ctrl_t;

    function automatic logic [2:0] alu_code(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_OUT: alu_code = 3'b000;
            OP_SUB, OP_SUBI:                       alu_code = 3'b001;
            OP_AND, OP_ANDI:                       alu_code = 3'b010;
            OP_OR, OP_ORI:                         alu_code = 3'b011;
            OP_MULT, OP_MULTI:                     alu_code = 3'b100;
            default:                               alu_code = 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] comp_code(input logic [OP_W-1:0] op);
        case (op)
            OP_SLT:  comp_code = 3'b100;
            OP_SGT:  comp_code = 3'b011;
            OP_DIV:  comp_code = 3'b110;
            OP_BEQ:  comp_code = 3'b001;
            OP_BNEQ: comp_code = 3'b010;
            OP_BEQZ: comp_code = 3'b101;
            OP_BEQO: comp_code = 3'b111;
            default: comp_code = 3'b000;
        endcase
    endfunction

    function automatic logic is_imm(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI, OP_MULTI,
            OP_MOVE, OP_LW, OP_SW, OP_OUT: is_imm = 1'b1;
            default:                       is_imm = 1'b0;
        endcase
    endfunction

    estado_t         state_q, state_d;
    logic [OP_W-1:0] opcode_q, opcode_d;
    logic            prim_q;
    ctrl_t           ctrl_q, ctrl_d;
    logic            legal_c;
    logic            ileg_c;

    assign legal_c = (opcode[OP_W-1:0] <= OP_INPUT) && ((opcode >> OP_W) == '0);

    // State, latched opcode and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BUSCA;
            opcode_q   <= '0;
            prim_q     <= 1'b1;
            ctrl_q     <= '0;
            ctrl_q.alu <= '1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            prim_q   <= 1'b0;
            ctrl_q   <= ctrl_d;
        end
    end

    // Next state, then the outputs of the state being entered
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        ileg_c     = 1'b0;
        ctrl_d     = '0;
        ctrl_d.alu = '1;

        case (state_q)
            BUSCA:      state_d = prim_q ? BUSCA : DECODIFICA;
            DECODIFICA: begin
                opcode_d = opcode[OP_W-1:0];
                if (legal_c) begin
                    state_d = EXECUTA;
                end else begin
                    state_d = BUSCA;
                    ileg_c  = 1'b1;
                end
            end
            EXECUTA: begin
                case (opcode_q)
                    OP_JUMP, OP_BEQ, OP_BNEQ, OP_BEQZ,
                    OP_BEQO, OP_NOP, OP_OUT: state_d = BUSCA;
                    OP_LW, OP_SW:            state_d = MEMORIA;
                    OP_INPUT:                state_d = ESPERA_ENTRADA;
                    OP_HALT:                 state_d = PARADO;
                    default:                 state_d = ESCRITA;
                endcase
            end
            MEMORIA:        if (mem_ready) state_d = (opcode_q == OP_LW) ? ESCRITA : BUSCA;
            ESPERA_ENTRADA: if (inp_valid) state_d = ESCRITA;
            ESCRITA:        state_d = BUSCA;
            PARADO:         if (continuar) state_d = BUSCA;
            default:        state_d = BUSCA;
        endcase

        if (state_d inside {EXECUTA, MEMORIA, ESPERA_ENTRADA, ESCRITA}) begin
            ctrl_d.alu         = ALU_W'(alu_code(opcode_d));
            ctrl_d.comp        = COMP_W'(comp_code(opcode_d));
            ctrl_d.imediato    = is_imm(opcode_d);
            ctrl_d.escolha_reg = is_imm(opcode_d);
        end

        case (state_d)
            BUSCA: begin
                ctrl_d.ir_load = 1'b1;
                ctrl_d.pc_inc  = 1'b1;
                ctrl_d.ilegal  = ileg_c;
            end
            EXECUTA: begin
                if (opcode_d == OP_JUMP) ctrl_d.condicional = 2'b01;
                if (opcode_d inside {OP_BEQ, OP_BNEQ, OP_BEQZ, OP_BEQO}) ctrl_d.condicional = 2'b10;
                ctrl_d.saida = (opcode_d == OP_OUT);
            end
            MEMORIA: begin
                ctrl_d.mem_read  = (opcode_d == OP_LW);
                ctrl_d.mem_write = (opcode_d == OP_SW);
            end
            ESPERA_ENTRADA: begin
                ctrl_d.entrada     = 1'b1;
                ctrl_d.escolhe_ext = 1'b1;
            end
            ESCRITA: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.origem_escrita = (opcode_d != OP_LW);
                ctrl_d.entrada        = (opcode_d == OP_INPUT);
                ctrl_d.escolhe_ext    = (opcode_d == OP_INPUT);
            end
            PARADO:  ctrl_d.halted = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_CONTADOR_INSTR_EN
    logic [CNT_W-1:0] cnt_q;
    logic             conta_c;

    // Retire on return to BUSCA from a completing state only
    assign conta_c = (state_d == BUSCA) && (state_q inside {EXECUTA, MEMORIA, ESCRITA});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (conta_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

    assign ir_load       = ctrl_q.ir_load;
    assign pc_inc        = ctrl_q.pc_inc;
    assign condicional   = ctrl_q.condicional;
    assign aluCtrl       = ctrl_q.alu;
    assign comp          = ctrl_q.comp;
    assign escolhaReg    = ctrl_q.escolha_reg;
    assign imediato      = ctrl_q.imediato;
    assign origemEscrita = ctrl_q.origem_escrita;
    assign memRead       = ctrl_q.mem_read;
    assign memWrite      = ctrl_q.mem_write;
    assign regWrite      = ctrl_q.reg_write;
    assign out           = ctrl_q.saida;
    assign inp           = ctrl_q.entrada;
    assign escolheExt    = ctrl_q.escolhe_ext;
    assign halted        = ctrl_q.halted;
    assign ilegal        = ctrl_q.ilegal;

endmodule

// File: doc/unidade_controle_multiciclo.md
UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 SHALL have parameter OPCODE_W, default 5, opcode width; must be >=5, and any set bit above bit 4 makes the opcode illegal.
REQ-002 SHALL have parameter ALU_W, default 3, width of aluCtrl; codes zero-extended.
REQ-003 SHALL have parameter COMP_W, default 3, width of comp; codes zero-extended.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset_n, in, 1, reset; asynchronous, active-low.
- opcode, in, OPCODE_W, current instruction opcode; sampled in DECODIFICA.
- mem_ready, in, 1, memory access complete.
- inp_valid, in, 1, input data available.
- continuar, in, 1, leave PARADO.
- ir_load, out, 1, load instruction register.
- pc_inc, out, 1, PC+1.
- condicional, out, 2: 01 jump, 10 branch, 00 none.
- aluCtrl, out, ALU_W, ULA operation.
- comp, out, COMP_W, compare code.
- escolhaReg, out, 1: 1 = RT, 0 = RD.
- imediato, out, 1: ULA B operand is the immediate.
- origemEscrita, out, 1: 1 = ULA, 0 = memory.
- memRead, out, 1, memory read.
- memWrite, out, 1, memory write.
- regWrite, out, 1, register file write.
- out, out, 1, display output.
- inp, out, 1, input read.
- escolheExt, out, 1, extender selects the input bus.
- halted, out, 1, processor stopped.
- ilegal, out, 1, one-cycle pulse on an undefined opcode.
- instr_count, out, 32, retired instruction count.

Function
REQ-005 SHALL implement FSM states BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESPERA_ENTRADA, ESCRITA, PARADO.
REQ-006 SHALL drive all outputs as functions of state and the latched opcode only (Moore); no combinational input-to-output path.
REQ-007 BUSCA SHALL assert ir_load and pc_inc for one cycle, then go to DECODIFICA.
REQ-008 DECODIFICA SHALL latch opcode, then go to EXECUTA; if the opcode is undefined it SHALL pulse ilegal and return to BUSCA.
REQ-009 EXECUTA SHALL hold aluCtrl, comp, imediato and escolhaReg from the decode table (REQ-010) for one cycle, then branch by opcode:
- jump (01000): condicional=01, go to BUSCA.
- beq 01101 / bneq 01110 / beqz 10100 / beqo 10111: condicional=10, comp=001/010/101/111, go to BUSCA.
- nop 10110: go to BUSCA.
- out 10011: out=1, go to BUSCA.
- lw 01001 / sw 01010: go to MEMORIA.
- input 11000: go to ESPERA_ENTRADA.
- halt 10000: go to PARADO.
- all other opcodes: go to ESCRITA.
REQ-010 aluCtrl decode table SHALL be:
- add/addi/lw/sw/out = 000.
- sub/subi = 001.
- and/andi = 010.
- or/ori = 011 (ori is corrected to 011).
- mult/multi = 100.
- all others = 111.
- comp: slt=100, sgt=011, div=110.
REQ-011 Immediate forms (addi, subi, ori, andi, multi, move, lw, sw, out) SHALL have imediato=1 and escolhaReg=1; register forms SHALL have 0/0.
REQ-012 MEMORIA SHALL hold memRead (lw) or memWrite (sw), address controls unchanged, until mem_ready=1; then lw goes to ESCRITA and sw goes to BUSCA.
REQ-013 ESPERA_ENTRADA SHALL hold inp=1 and escolheExt=1 until inp_valid=1, then go to ESCRITA.
REQ-014 ESCRITA SHALL assert regWrite for exactly one cycle with origemEscrita=0 for lw and 1 otherwise; for input, inp and escolheExt SHALL remain 1; then go to BUSCA.
REQ-015 PARADO SHALL hold halted=1, all write strobes 0, until continuar=1, then go to BUSCA; continuar in any other state SHALL be ignored.
REQ-016 Latency SHALL be:
- ALU instruction: 4 cycles.
- Jump, branch, nop or out: 3 cycles.
- lw: 4 cycles + memory wait.
- sw: 3 cycles + memory wait.
REQ-017 Outside the states named above, every strobe SHALL be 0.

Reset
REQ-018 On reset_n=0, the block SHALL enter BUSCA asynchronously, clear the opcode register and instr_count, and drive all outputs to 0 except aluCtrl, which SHALL be all ones.
REQ-019 Reset asserted mid-MEMORIA or mid-ESPERA_ENTRADA SHALL deassert memRead, memWrite and inp immediately, with no write strobe issued.
REQ-020 After reset_n rises, the first BUSCA cycle SHALL be the first clock edge.

Configuration
REQ-021 With macro CTRL_CONTADOR_INSTR_EN defined, instr_count SHALL increment (wrapping at 2^32) on every transition into BUSCA from EXECUTA, MEMORIA or ESCRITA; ilegal and PARADO exits SHALL not count.
REQ-022 Without CTRL_CONTADOR_INSTR_EN, instr_count SHALL be constant 0 and no counter logic shall exist.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- add (00000) -> states BUSCA, DECODIFICA, EXECUTA, ESCRITA; aluCtrl=000, regWrite=1 only in cycle 4, escolhaReg=0.
- lw (01001) with mem_ready delayed 3 cycles -> memRead=1 for 4 cycles, then regWrite=1 with origemEscrita=0.
- input (11000) with inp_valid after 5 cycles -> inp=1 and escolheExt=1 throughout, then a single regWrite.
- halt (10000), then continuar after 10 cycles -> halted=1 for 10 cycles, then BUSCA with ir_load=1.
- opcode 11111 -> ilegal pulse, no strobes; reset_n low during MEMORIA -> memWrite=0 asynchronously.
- With CTRL_CONTADOR_INSTR_EN, 5 instructions (add, beq, sw, out, halt) -> instr_count=4.
